// File: rtl/fft_bin_serializer_if.sv
// Beat-side and bin-side bundles for fft_bin_serializer.
// The FFT drives beats with no backpressure; the bin side is valid/ready.
interface fft_beat_if #(
  parameter int S_WIDTH = 32
) ();
  logic                      valid_i;
  logic signed [S_WIDTH-1:0] re1;
  logic signed [S_WIDTH-1:0] im1;
  logic signed [S_WIDTH-1:0] re2;
  logic signed [S_WIDTH-1:0] im2;

  modport master (
    output valid_i, re1, im1, re2, im2
  );
  modport slave (
    input valid_i, re1, im1, re2, im2
  );
endinterface

interface fft_bin_if #(
  parameter int S_WIDTH = 32,
  parameter int BIN_W   = 2
) ();
  logic                      valid_o;
  logic                      ready_i;
  logic signed [S_WIDTH-1:0] re_o;
  logic signed [S_WIDTH-1:0] im_o;
  logic [BIN_W-1:0]          bin_o;
  logic                      last_o;
  logic                      overflow_o;

  modport master (
    output valid_o, re_o, im_o, bin_o, last_o, overflow_o,
    input  ready_i
  );
  modport slave (
    input  valid_o, re_o, im_o, bin_o, last_o, overflow_o,
    output ready_i
  );
endinterface

// File: rtl/fft_bin_serializer.sv
// Ping-pong frame buffer turning two-bin FFT beats into a
// one-bin-per-cycle valid/ready stream, dropping frames when both banks are full.
module fft_bin_serializer #(
  parameter int  S_WIDTH      = 32,
  parameter int  FRAME_LENGTH = 4,
  localparam int BIN_W = (FRAME_LENGTH > 2) ? $clog2(FRAME_LENGTH) : 1,
  localparam int HALF  = FRAME_LENGTH / 2,
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic      clk,
  input  logic      arstn,
  fft_beat_if.slave in_if,
  fft_bin_if.master out_if
);

  typedef logic signed [S_WIDTH-1:0] word_t;

  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(FRAME_LENGTH - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HALF - 1);

  word_t mem_re_q [2][FRAME_LENGTH];
  word_t mem_im_q [2][FRAME_LENGTH];

  logic [1:0]       full_q;
  logic [1:0]       ripe_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic             drop_q;
  logic [CNT_W-1:0] wr_cnt_q;

  logic             valid_q;
  logic             last_q;
  logic             ovf_q;
  logic [BIN_W-1:0] bin_q;
  word_t            re_q;
  word_t            im_q;

  logic             hs;
  logic             free;
  logic             mid;
  logic             first;
  logic             wr_en;
  logic             wr_last;
  logic             rd_bank_d;
  logic             load;
  logic [1:0]       full_fr;
  logic [1:0]       full_d;
  logic [BIN_W-1:0] wr_idx;
  logic [BIN_W-1:0] nxt_bin;

  always_comb begin
    hs      = valid_q & out_if.ready_i;
    free    = hs & last_q;
    mid     = hs & ~last_q;
    full_fr = full_q;
    if (free) full_fr[rd_bank_q] = 1'b0;
    rd_bank_d = rd_bank_q ^ free;
    first   = in_if.valid_i & (wr_cnt_q == '0);
    wr_last = (wr_cnt_q == LAST_BEAT);
    // The frame decision on its first beat sticks for the remaining beats.
    wr_en   = in_if.valid_i
            & (first ? ~full_fr[wr_bank_q] : ~drop_q);
    full_d  = full_fr;
    if (wr_en && wr_last) full_d[wr_bank_q] = 1'b1;
    // From idle a bank must have been full for one whole cycle (ripe);
    // chaining straight from a previous frame's last bin needs only full.
    load    = (~valid_q | free)
            & full_fr[rd_bank_d]
            & (valid_q | ripe_q[rd_bank_d]);
    wr_idx  = BIN_W'({wr_cnt_q, 1'b0});
    nxt_bin = bin_q + BIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (arstn && wr_en) begin
      mem_re_q[wr_bank_q][wr_idx] <= in_if.re1;
      mem_im_q[wr_bank_q][wr_idx] <= in_if.im1;
      mem_re_q[wr_bank_q][wr_idx | BIN_W'(1)] <= in_if.re2;
      mem_im_q[wr_bank_q][wr_idx | BIN_W'(1)] <= in_if.im2;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      full_q    <= '0;
      ripe_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      drop_q    <= 1'b0;
      wr_cnt_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bin_q     <= '0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      full_q    <= full_d;
      ripe_q    <= full_fr;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= first & full_fr[wr_bank_q];
      if (in_if.valid_i) begin
        wr_cnt_q <= wr_last ? '0 : wr_cnt_q + CNT_W'(1);
        if (first) drop_q <= full_fr[wr_bank_q];
        if (wr_en && wr_last) wr_bank_q <= ~wr_bank_q;
      end
      if (mid) begin
        bin_q  <= nxt_bin;
        last_q <= (nxt_bin == LAST_BIN);
        re_q   <= mem_re_q[rd_bank_q][nxt_bin];
        im_q   <= mem_im_q[rd_bank_q][nxt_bin];
      end else if (load) begin
        valid_q <= 1'b1;
        bin_q   <= '0;
        last_q  <= 1'b0;
        re_q    <= mem_re_q[rd_bank_d][0];
        im_q    <= mem_im_q[rd_bank_d][0];
      end else if (free) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign out_if.valid_o    = valid_q;
  assign out_if.re_o       = re_q;
  assign out_if.im_o       = im_q;
  assign out_if.bin_o      = bin_q;
  assign out_if.last_o     = last_q;
  assign out_if.overflow_o = ovf_q;

endmodule
